// File: rtl/hps_csr_bank.sv
// hps_csr_bank: HPS-facing Avalon-MM control/status register bank.
//
// Word-addressed slave that drives the synchroniser, LED-band controller and row muxes.
// It provides read-back of all registers, multi-word SOUT storage, a self-clearing
// new_frame pulse, a multi-source interrupt block and a turn counter.
//
// Ports:
//   clk, rst_in             - system clock, asynchronous active-high reset
//   address                 - word address
//   writedata, write        - write data and one-cycle write strobe
//   read                    - one-cycle read strobe
//   readdata, readdatavalid - registered read data, valid one cycle after read
//   rst_out .. PD           - decoded CTRL bits
//   hps_SOUT                - SOUT words concatenated, LSB first
//   hps_row_en              - ROW_EN register
//   irq_src                 - interrupt sources, possibly from another clock domain
//   irq                     - registered |(IRQ_STATUS & IRQ_ENABLE)
//
// Address map (word):
//   0 CTRL, 1 ROW_EN, 4..7 SOUT0..3, 8 IRQ_STATUS (W1C), 9 IRQ_ENABLE,
//   10 IRQ_EDGE (1=rising), 11 TURN_COUNT (RO, write clears), 12 VERSION.
//   All other addresses read 0 and ignore writes.
module hps_csr_bank #(
  parameter int unsigned W_ADDR_WIDTH = 4,
  parameter int unsigned W_DATA_WIDTH = 32,
  parameter int unsigned NB_LED_BAND  = 20,
  parameter int unsigned NB_MUX_ROWS  = 4,
  parameter int unsigned NB_IRQ       = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [31:0] VERSION      = 32'h0002_0000
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic [W_ADDR_WIDTH-1:0] address,
  input  logic [W_DATA_WIDTH-1:0] writedata,
  input  logic                    write,
  input  logic                    read,
  output logic [W_DATA_WIDTH-1:0] readdata,
  output logic                    readdatavalid,
  output logic                    rst_out,
  output logic                    new_frame,
  output logic                    write_fc,
  output logic                    hps_override_sync,
  output logic                    hps_override_lbc,
  output logic                    hps_LAT,
  output logic                    hps_SCLK,
  output logic                    hps_turn_tick,
  output logic                    PD,
  output logic [NB_LED_BAND-1:0]  hps_SOUT,
  output logic [NB_MUX_ROWS-1:0]  hps_row_en,
  input  logic [NB_IRQ-1:0]       irq_src,
  output logic                    irq
);

  localparam logic [W_ADDR_WIDTH-1:0] AddrCtrl      = W_ADDR_WIDTH'(0);
  localparam logic [W_ADDR_WIDTH-1:0] AddrRowEn     = W_ADDR_WIDTH'(1);
  localparam logic [W_ADDR_WIDTH-1:0] AddrSout0     = W_ADDR_WIDTH'(4);
  localparam logic [W_ADDR_WIDTH-1:0] AddrSout1     = W_ADDR_WIDTH'(5);
  localparam logic [W_ADDR_WIDTH-1:0] AddrSout2     = W_ADDR_WIDTH'(6);
  localparam logic [W_ADDR_WIDTH-1:0] AddrSout3     = W_ADDR_WIDTH'(7);
  localparam logic [W_ADDR_WIDTH-1:0] AddrIrqStatus = W_ADDR_WIDTH'(8);
  localparam logic [W_ADDR_WIDTH-1:0] AddrIrqEnable = W_ADDR_WIDTH'(9);
  localparam logic [W_ADDR_WIDTH-1:0] AddrIrqEdge   = W_ADDR_WIDTH'(10);
  localparam logic [W_ADDR_WIDTH-1:0] AddrTurnCount = W_ADDR_WIDTH'(11);
  localparam logic [W_ADDR_WIDTH-1:0] AddrVersion   = W_ADDR_WIDTH'(12);

  // Register state
  logic [7:0]             ctrl_q, ctrl_d;
  logic                   new_frame_q, new_frame_d;
  logic [NB_MUX_ROWS-1:0] row_en_q, row_en_d;
  logic [NB_LED_BAND-1:0] sout_q, sout_d;
  logic [NB_IRQ-1:0]      status_q, status_d;
  logic [NB_IRQ-1:0]      enable_q, enable_d;
  logic [NB_IRQ-1:0]      edge_sel_q, edge_sel_d;
  logic [NB_IRQ-1:0]      prev_q;
  logic [31:0]            turn_count_q, turn_count_d;
  logic                   irq_q;
  logic [31:0]            readdata_q, readdata_d;
  logic                   readdatavalid_q;

  logic [NB_IRQ-1:0]      src_s;
  logic [NB_IRQ-1:0]      edge_vec;
  logic [NB_IRQ-1:0]      w1c_mask;
  logic [127:0]           sout_pad;

  // Not every writedata bit lands in a register for every parameter set.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  // Write strobes
  logic wr_ctrl, wr_row_en, wr_status, wr_enable, wr_edge, wr_turn;
  assign wr_ctrl   = write && (address == AddrCtrl);
  assign wr_row_en = write && (address == AddrRowEn);
  assign wr_status = write && (address == AddrIrqStatus);
  assign wr_enable = write && (address == AddrIrqEnable);
  assign wr_edge   = write && (address == AddrIrqEdge);
  assign wr_turn   = write && (address == AddrTurnCount);

  // Source synchroniser
  if (SYNC_STAGES == 0) begin : g_no_sync
    assign src_s = irq_src;
  end else begin : g_sync
    logic [NB_IRQ-1:0] sync_q [SYNC_STAGES];
    always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
        for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
        sync_q[0] <= irq_src;
        for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end
    assign src_s = sync_q[SYNC_STAGES-1];
  end

  // Per-source edge select: 1 = rising, 0 = falling.
  assign edge_vec = (edge_sel_q & src_s & ~prev_q) | (~edge_sel_q & ~src_s & prev_q);
  assign w1c_mask = wr_status ? writedata[NB_IRQ-1:0] : '0;

  // Next-state logic
  always_comb begin
    ctrl_d       = ctrl_q;
    new_frame_d  = 1'b0;
    row_en_d     = row_en_q;
    sout_d       = sout_q;
    enable_d     = enable_q;
    edge_sel_d   = edge_sel_q;
    turn_count_d = turn_count_q;

    if (wr_ctrl) begin
      // Bit 1 is a strobe only; it is never stored.
      ctrl_d      = writedata[7:0] & 8'hFD;
      new_frame_d = writedata[1];
    end
    if (wr_row_en) row_en_d   = writedata[NB_MUX_ROWS-1:0];
    if (wr_enable) enable_d   = writedata[NB_IRQ-1:0];
    if (wr_edge)   edge_sel_d = writedata[NB_IRQ-1:0];

    // Only bits below NB_LED_BAND exist, so unimplemented words ignore writes.
    for (int i = 0; i < int'(NB_LED_BAND); i++) begin
      if (write && (address == W_ADDR_WIDTH'(4 + i / 32))) sout_d[i] = writedata[i % 32];
    end

    // A set on the same cycle beats a clear so no event is lost.
    status_d = (status_q & ~w1c_mask) | edge_vec;

    // Falling edges of source 0 count turns regardless of its edge select;
    // a write wins over a simultaneous increment.
    if (wr_turn) begin
      turn_count_d = '0;
    end else if (~src_s[0] & prev_q[0]) begin
      turn_count_d = turn_count_q + 32'd1;
    end
  end

  // Read mux on the pre-write state
  always_comb begin
    sout_pad                   = '0;
    sout_pad[NB_LED_BAND-1:0]  = sout_q;
  end

  always_comb begin
    readdata_d = readdata_q;
    if (read) begin
      case (address)
        AddrCtrl:      readdata_d = {24'd0, ctrl_q};
        AddrRowEn:     readdata_d = 32'(row_en_q);
        AddrSout0:     readdata_d = sout_pad[31:0];
        AddrSout1:     readdata_d = sout_pad[63:32];
        AddrSout2:     readdata_d = sout_pad[95:64];
        AddrSout3:     readdata_d = sout_pad[127:96];
        AddrIrqStatus: readdata_d = 32'(status_q);
        AddrIrqEnable: readdata_d = 32'(enable_q);
        AddrIrqEdge:   readdata_d = 32'(edge_sel_q);
        AddrTurnCount: readdata_d = turn_count_q;
        AddrVersion:   readdata_d = VERSION;
        default:       readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      ctrl_q          <= '0;
      new_frame_q     <= 1'b0;
      row_en_q        <= '0;
      sout_q          <= '0;
      status_q        <= '0;
      enable_q        <= '0;
      edge_sel_q      <= '0;
      prev_q          <= '0;
      turn_count_q    <= '0;
      irq_q           <= 1'b0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      ctrl_q          <= ctrl_d;
      new_frame_q     <= new_frame_d;
      row_en_q        <= row_en_d;
      sout_q          <= sout_d;
      status_q        <= status_d;
      enable_q        <= enable_d;
      edge_sel_q      <= edge_sel_d;
      prev_q          <= src_s;
      turn_count_q    <= turn_count_d;
      irq_q           <= |(status_q & enable_q);
      readdata_q      <= readdata_d;
      readdatavalid_q <= read;
    end
  end

  // Outputs
  assign readdata          = readdata_q;
  assign readdatavalid     = readdatavalid_q;
  assign rst_out           = ctrl_q[0];
  assign new_frame         = new_frame_q;
  assign write_fc          = ctrl_q[2];
  assign hps_override_sync = ctrl_q[3];
  assign hps_override_lbc  = ctrl_q[3];
  assign hps_LAT           = ctrl_q[4];
  assign hps_SCLK          = ctrl_q[5];
  assign hps_turn_tick     = ctrl_q[6];
  assign PD                = ~ctrl_q[7];
  assign hps_SOUT          = sout_q;
  assign hps_row_en        = row_en_q;
  assign irq               = irq_q;

endmodule

// File: tb/tb_hps_csr_bank.sv
module tb_hps_csr_bank;

  localparam int unsigned AW     = 4;
  localparam int unsigned NbLed  = 40;
  localparam int unsigned NbRows = 4;
  localparam int unsigned NbIrq  = 4;
  localparam int unsigned Sync   = 2;
  localparam logic [31:0] Ver    = 32'h0002_0000;

  logic              clk = 1'b0;
  logic              rst_in;
  logic [AW-1:0]     address;
  logic [31:0]       writedata;
  logic              write, read;
  logic [31:0]       readdata;
  logic              readdatavalid;
  logic              rst_out, new_frame, write_fc, hps_override_sync, hps_override_lbc;
  logic              hps_LAT, hps_SCLK, hps_turn_tick, PD;
  logic [NbLed-1:0]  hps_SOUT;
  logic [NbRows-1:0] hps_row_en;
  logic [NbIrq-1:0]  irq_src;
  logic              irq;

  hps_csr_bank #(
    .W_ADDR_WIDTH(AW),
    .W_DATA_WIDTH(32),
    .NB_LED_BAND (NbLed),
    .NB_MUX_ROWS (NbRows),
    .NB_IRQ      (NbIrq),
    .SYNC_STAGES (Sync),
    .VERSION     (Ver)
  ) dut (
    .clk              (clk),
    .rst_in           (rst_in),
    .address          (address),
    .writedata        (writedata),
    .write            (write),
    .read             (read),
    .readdata         (readdata),
    .readdatavalid    (readdatavalid),
    .rst_out          (rst_out),
    .new_frame        (new_frame),
    .write_fc         (write_fc),
    .hps_override_sync(hps_override_sync),
    .hps_override_lbc (hps_override_lbc),
    .hps_LAT          (hps_LAT),
    .hps_SCLK         (hps_SCLK),
    .hps_turn_tick    (hps_turn_tick),
    .PD               (PD),
    .hps_SOUT         (hps_SOUT),
    .hps_row_en       (hps_row_en),
    .irq_src          (irq_src),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
  endtask

  // Issues one read, then checks the one-cycle valid pulse and the data.
  task automatic bus_rd(input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    address = a;
    read    = 1'b1;
    @(negedge clk);
    read    = 1'b0;
    check_val({tag, "_valid"}, 64'(readdatavalid), 64'd1);
    check_val(tag, 64'(readdata), 64'(exp));
    @(negedge clk);
    check_val({tag, "_valid_end"}, 64'(readdatavalid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in    = 1'b1;
    address   = '0;
    writedata = '0;
    write     = 1'b0;
    read      = 1'b0;
    irq_src   = '0;
    repeat (3) @(negedge clk);
    check_val("rst_pd", 64'(PD), 64'd1);
    check_val("rst_valid", 64'(readdatavalid), 64'd0);
    check_val("rst_irq", 64'(irq), 64'd0);
    rst_in = 1'b0;

    // Reset contents of the whole map
    for (int a = 0; a < 16; a++) begin
      bus_rd(AW'(a), (a == 12) ? Ver : 32'd0, $sformatf("rst_rd%0d", a));
    end

    // CTRL and new_frame pulse
    bus_wr(0, 32'h0000_0086);
    check_val("nf_high", 64'(new_frame), 64'd1);
    check_val("write_fc", 64'(write_fc), 64'd1);
    check_val("pd_low", 64'(PD), 64'd0);
    @(negedge clk);
    check_val("nf_low", 64'(new_frame), 64'd0);
    bus_rd(0, 32'h0000_0084, "ctrl_rd");

    // SOUT packing with a 40-bit band
    bus_wr(4, 32'hFFFF_FFFF);
    bus_wr(5, 32'hFFFF_FFFF);
    check_val("sout_out", 64'(hps_SOUT), 64'hFF_FFFF_FFFF);
    bus_rd(5, 32'h0000_00FF, "sout1_rd");
    bus_rd(6, 32'h0, "sout2_rd");
    bus_wr(6, 32'h1234_5678);
    bus_rd(6, 32'h0, "sout2_ignore");

    // ROW_EN truncation
    bus_wr(1, 32'hFFFF_FFFF);
    check_val("row_en_out", 64'(hps_row_en), 64'hF);
    bus_rd(1, 32'h0000_000F, "row_en_rd");

    // Falling-edge interrupt on source 0 with exact latency
    bus_wr(10, 32'h0);
    bus_wr(9, 32'h1);
    @(negedge clk);
    irq_src[0] = 1'b1;
    repeat (6) @(negedge clk);
    check_val("irq_no_rise", 64'(irq), 64'd0);
    irq_src[0] = 1'b0;
    repeat (3) @(negedge clk);
    check_val("irq_early", 64'(irq), 64'd0);
    @(negedge clk);
    check_val("irq_set", 64'(irq), 64'd1);
    bus_rd(8, 32'h1, "status_rd");
    bus_rd(11, 32'h1, "turn_rd1");
    bus_wr(8, 32'h1);
    check_val("irq_hold_clr", 64'(irq), 64'd1);
    @(negedge clk);
    check_val("irq_clr", 64'(irq), 64'd0);
    bus_rd(8, 32'h0, "status_clr_rd");

    // W1C in the same cycle as a new edge: the set wins
    @(negedge clk);
    irq_src[0] = 1'b1;
    repeat (6) @(negedge clk);
    irq_src[0] = 1'b0;
    repeat (2) @(negedge clk);
    address   = 8;
    writedata = 32'h1;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
    @(negedge clk);
    check_val("irq_race", 64'(irq), 64'd1);
    repeat (3) @(negedge clk);
    check_val("irq_race_hold", 64'(irq), 64'd1);
    bus_rd(8, 32'h1, "status_race_rd");
    bus_rd(11, 32'h2, "turn_rd2");

    // Disable masks irq but keeps status
    bus_wr(9, 32'h0);
    @(negedge clk);
    check_val("irq_masked", 64'(irq), 64'd0);
    bus_rd(8, 32'h1, "status_kept");

    // Rising edge select on source 1
    bus_wr(10, 32'h2);
    irq_src[1] = 1'b1;
    repeat (4) @(negedge clk);
    bus_rd(8, 32'h3, "status_rise");

    // Any write clears TURN_COUNT
    bus_wr(11, 32'hDEAD_BEEF);
    bus_rd(11, 32'h0, "turn_clr");

    // Same-cycle read and write of CTRL
    @(negedge clk);
    address   = 0;
    writedata = 32'h0000_0009;
    write     = 1'b1;
    read      = 1'b1;
    @(negedge clk);
    write     = 1'b0;
    read      = 1'b0;
    check_val("rw_valid", 64'(readdatavalid), 64'd1);
    check_val("rw_old", 64'(readdata), 64'h84);
    check_val("rw_rst_out", 64'(rst_out), 64'd1);
    check_val("rw_ovr_lbc", 64'(hps_override_lbc), 64'd1);
    check_val("rw_pd", 64'(PD), 64'd1);
    bus_rd(0, 32'h0000_0009, "rw_new");

    // Reset in the middle of a read
    bus_wr(9, 32'h3);
    @(negedge clk);
    check_val("irq_reen", 64'(irq), 64'd1);
    address = 12;
    read    = 1'b1;
    @(posedge clk);
    #1;
    read   = 1'b0;
    rst_in = 1'b1;
    #1;
    check_val("mid_rst_valid", 64'(readdatavalid), 64'd0);
    check_val("mid_rst_irq", 64'(irq), 64'd0);
    check_val("mid_rst_rst_out", 64'(rst_out), 64'd0);
    check_val("mid_rst_pd", 64'(PD), 64'd1);
    check_val("mid_rst_sout", 64'(hps_SOUT), 64'd0);
    check_val("mid_rst_row", 64'(hps_row_en), 64'd0);
    check_val("mid_rst_ovr", 64'(hps_override_sync), 64'd0);
    @(negedge clk);
    rst_in = 1'b0;
    bus_rd(0, 32'h0, "post_rst_ctrl");
    bus_rd(8, 32'h0, "post_rst_status");
    bus_rd(12, Ver, "post_rst_ver");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hps_csr_bank.md
Name: hps_csr_bank

Overview:
Parametrised HPS-facing control/status register bank that drives the synchronizer, LED-band controller and row muxes. It replaces the single write-only control word with a word-addressed Avalon-MM slave offering:
- read-back of all registers;
- multi-word SOUT storage for wide LED bands;
- a self-clearing new_frame pulse;
- a generalised multi-source interrupt block with per-source edge select, enable and write-1-to-clear status;
- a turn counter.

Parameters:
W_ADDR_WIDTH, 4, word address width; map below needs ≥4.
W_DATA_WIDTH, 32, Avalon data width; fixed at 32.
NB_LED_BAND, 20, hps_SOUT width, 1..128; packed LSB-first into 32-bit words.
NB_MUX_ROWS, 4, hps_row_en width, 1..32.
NB_IRQ, 4, interrupt source count, 1..32; irq_src[0] is turn_tick by convention.
SYNC_STAGES, 2, synchroniser flops on irq_src, 0..3 (0 = sources already in clk domain).
VERSION, 32'h0002_0000, constant returned at VERSION address.

Ports:
clk  in  1  system clock
rst_in  in  1  asynchronous active-high reset
address  in  W_ADDR_WIDTH  word address
writedata  in  32  write data
write  in  1  write strobe, one cycle per access
read  in  1  read strobe, one cycle per access
readdata  out  32  read data, valid with readdatavalid
readdatavalid  out  1  one-cycle pulse, 1 cycle after read
rst_out  out  1  module reset, CTRL[0]
new_frame  out  1  one-cycle pulse on write of CTRL[1]=1
write_fc  out  1  CTRL[2]
hps_override_sync  out  1  CTRL[3]
hps_override_lbc  out  1  copy of CTRL[3]
hps_LAT  out  1  CTRL[4]
hps_SCLK  out  1  CTRL[5]
hps_turn_tick  out  1  CTRL[6]
PD  out  1  ~CTRL[7] (power-down asserted unless enabled)
hps_SOUT  out  NB_LED_BAND  SOUT words concatenated
hps_row_en  out  NB_MUX_ROWS  ROW_EN register
irq_src  in  NB_IRQ  interrupt sources
irq  out  1  registered |(IRQ_STATUS & IRQ_ENABLE)

Behaviour:
- Reset: every register, pipeline flop and sync flop is 0. Consequently:
  - all outputs are 0 except PD=1;
  - irq=0 and readdatavalid=0;
  - prev-edge flops are 0, so a source already high at reset release reports a rising edge one cycle later if its edge select is rising.
- Address map (word):
  - 0 CTRL RW: bits[7:0] as listed; bit1 reads 0; unused bits read 0.
  - 1 ROW_EN RW [NB_MUX_ROWS-1:0].
  - 4..7 SOUT0..SOUT3 RW, only up to ceil(NB_LED_BAND/32) words implemented. Bits above NB_LED_BAND are not stored and read 0. Unimplemented words read 0 and ignore writes.
  - 8 IRQ_STATUS, write-1-to-clear.
  - 9 IRQ_ENABLE RW.
  - 10 IRQ_EDGE RW, per source: 1=rising, 0=falling.
  - 11 TURN_COUNT RO; counts falling edges of synchronised irq_src[0], wraps at 2^32; any write clears it to 0.
  - 12 VERSION RO.
  - Any other address reads 0 and ignores writes.
- Writes take effect on the clk edge where write=1; outputs change the same edge.
- new_frame: high exactly for the cycle after a CTRL write with bit1=1. Back-to-back writes give back-to-back pulses.
- Reads:
  - readdata is registered from the pre-write register state of the read cycle, with readdatavalid=1 the next cycle.
  - If write and read occur in the same cycle, both are performed and the read returns the old value.
  - readdata holds its last value while readdatavalid=0.
- Edge detection: on synchronised source s with previous value p, an edge fires when IRQ_EDGE[i] ? (s&~p) : (~s&p).
- Status update: status_next = (status & ~w1c_mask) | edge_vec. On the same cycle, a set beats a clear, so no event is lost.
- irq is registered, 1 cycle after status/enable change.
- Disabling a source masks irq but keeps its status bit.
- TURN_COUNT increment and a write in the same cycle → result 0.
- rst_in asserted mid-operation clears all state immediately, including an in-flight readdatavalid.

Test Plan:
- Reset release, then read all addresses 0..15 → CTRL=0, VERSION=32'h0002_0000, every other address 0; PD=1; readdatavalid exactly 1 cycle after each read.
- Write CTRL=32'h0000_0086 → write_fc=1, PD=0, new_frame high exactly one cycle. Read CTRL → 32'h0000_0084.
- NB_LED_BAND=40: write SOUT0=32'hFFFF_FFFF, SOUT1=32'hFFFF_FFFF → hps_SOUT=40'hFF_FFFF_FFFF. Read SOUT1 → 32'h0000_00FF; read SOUT2 → 0.
- IRQ_EDGE=0, IRQ_ENABLE=1, falling edge on irq_src[0] → STATUS=1 and irq=1 after SYNC_STAGES+2 cycles; TURN_COUNT=1. Write STATUS=1 → irq drops 1 cycle later.
- Write-1-to-clear of bit0 in the same cycle as a new edge on source 0 → STATUS bit0 stays 1, irq stays 1.
- Read and write CTRL in the same cycle → readdata is the old value, next read returns the new one. Assert rst_in mid-read → readdatavalid=0 and all outputs return to reset values.
